tile_bist_driver: RTL and testbench

TILE_BIST_DRIVER -- requirements
Module: tile_bist_driver

---
 rtl/tile_bist_pkg.sv | 25 ++
 rtl/tile_bist_misr16.sv | 33 +++
 rtl/tile_bist_driver.sv | 118 +++++++++++
 tb/tb_tile_bist_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_bist_pkg.sv
// Shared types, constants and step functions for the tile BIST driver.
// The LFSR and MISR update rules live here so the driver and the MISR agree.
package tile_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } bist_state_e;

    // Taps at bits 7,5,4,3 feed bit 0 after the left shift
    localparam logic [7:0]  LFSR_TAP_MASK     = 8'hB8;
    localparam logic [15:0] MISR_POLY         = 16'h1021;
    localparam logic [7:0]  DEFAULT_LFSR_SEED = 8'h01;
    localparam logic [15:0] DEFAULT_MISR_SEED = 16'hFFFF;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [7:0] data);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {8'h00, data};
    endfunction

endpackage

// File: rtl/tile_bist_misr16.sv
// 16-bit multiple-input signature register compacting 8-bit tile responses.
// clear has priority over enable so a run always starts from the seed.
module misr16
    import tile_bist_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_MISR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] sig
);

    logic [15:0] sig_r;

    // Signature register: seed on reset/clear, compact on enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else if (clear) begin
            sig_r <= SEED;
        end else if (enable) begin
            sig_r <= misr_step(sig_r, data);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/tile_bist_driver.sv
// Drives LFSR stimulus into a tile under test, holding each vector for
// SETTLE_CYCLES+1 cycles, and compacts the sampled responses into a MISR.
module tile_bist_driver
    import tile_bist_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED     = DEFAULT_LFSR_SEED,
    parameter logic [15:0] MISR_SEED     = DEFAULT_MISR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_vectors,
    output logic [7:0]  tile_ui_in,
    input  logic [7:0]  tile_uo_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam logic [3:0] SETTLE_LAST = SETTLE_CYCLES[3:0];

    bist_state_e state_r, state_s;
    logic [7:0]  lfsr_r, lfsr_s;
    logic [8:0]  remaining_r, remaining_s;
    logic [3:0]  settle_r, settle_s;
    logic [7:0]  tile_ui_in_r, tile_ui_in_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        misr_clear_s;
    logic        misr_enable_s;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= LFSR_SEED;
            remaining_r  <= 9'd0;
            settle_r     <= 4'd0;
            tile_ui_in_r <= 8'h00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            lfsr_r       <= lfsr_s;
            remaining_r  <= remaining_s;
            settle_r     <= settle_s;
            tile_ui_in_r <= tile_ui_in_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step
    always_comb begin
        state_s       = state_r;
        lfsr_s        = lfsr_r;
        remaining_s   = remaining_r;
        settle_s      = settle_r;
        misr_clear_s  = 1'b0;
        misr_enable_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s      = ST_DRIVE;
                    lfsr_s       = LFSR_SEED;
                    remaining_s  = (num_vectors == 8'h00) ? 9'd256 : {1'b0, num_vectors};
                    settle_s     = 4'd0;
                    misr_clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (settle_r == SETTLE_LAST) begin
                    settle_s      = 4'd0;
                    misr_enable_s = 1'b1;
                    lfsr_s        = lfsr_step(lfsr_r);
                    remaining_s   = remaining_r - 9'd1;
                    if (remaining_r == 9'd1) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DRIVE;
                    end
                end else begin
                    settle_s = settle_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        tile_ui_in_s = (state_s == ST_DRIVE) ? lfsr_s : 8'h00;
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_DONE);
    end

    misr16 #(
        .SEED (MISR_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misr_clear_s),
        .enable (misr_enable_s),
        .data   (tile_uo_out),
        .sig    (signature)
    );

    assign tile_ui_in = tile_ui_in_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_tile_bist_driver.sv
// Scoreboard bench for tile_bist_driver: expected vectors and signatures are
// queued from a bench-side model when a run is launched, then popped per cycle.
module tb_tile_bist_driver;

    localparam int SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_vectors;
    logic [7:0]  tile_ui_in;
    logic [7:0]  tile_uo_out;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic        tile_loop;

    int n_cmp;
    int n_bad;

    logic [7:0]  exp_ui_q[$];
    logic [15:0] exp_sig_q[$];
    logic [15:0] last_sig;

    tile_bist_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_vectors (num_vectors),
        .tile_ui_in  (tile_ui_in),
        .tile_uo_out (tile_uo_out),
        .busy        (busy),
        .done        (done),
        .signature   (signature)
    );

    assign tile_uo_out = tile_loop ? tile_ui_in : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_lfsr(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [7:0] r);
        logic [15:0] t;
        t = s << 1;
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {8'h00, r};
    endfunction

    // One full run: queue expectations, then check every cycle through the IDLE after done.
    // chain=1 raises start in the DONE cycle and leaves it high for the next run.
    task automatic do_run(input int nv, input bit loop, input bit mid, input bit chain);
        int n;
        int total;
        logic [7:0]  v;
        logic [15:0] s;
        logic [7:0]  got_ui;
        logic [15:0] got_sig;
        n = (nv == 0) ? 256 : nv;
        total = n * (SETTLE + 1);
        v = 8'h01;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c <= SETTLE; c++) exp_ui_q.push_back(v);
            s = model_misr(s, loop ? v : 8'h00);
            v = model_lfsr(v);
        end
        exp_sig_q.push_back(s);
        tile_loop = loop;
        num_vectors = nv[7:0];
        start = 1'b1;
        for (int k = 1; k <= total + 2; k++) begin
            @(negedge clk);
            if (k <= total) begin
                got_ui = (exp_ui_q.size() > 0) ? exp_ui_q.pop_front() : 8'hxx;
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0 || tile_ui_in !== got_ui) begin
                    n_bad++;
                    $display("FAIL drive n=%0d cyc=%0d: busy=%b done=%b ui=%h, required busy=1 done=0 ui=%h",
                             n, k, busy, done, tile_ui_in, got_ui);
                end
            end else if (k == total + 1) begin
                got_sig = (exp_sig_q.size() > 0) ? exp_sig_q.pop_front() : 16'hxxxx;
                last_sig = got_sig;
                n_cmp++;
                if (done !== 1'b1 || busy !== 1'b1 || tile_ui_in !== 8'h00 || signature !== got_sig) begin
                    n_bad++;
                    $display("FAIL done_cycle n=%0d cyc=%0d: done=%b busy=%b ui=%h sig=%h, required 1 1 00 %h",
                             n, k, done, busy, tile_ui_in, signature, got_sig);
                end
            end else begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0 || tile_ui_in !== 8'h00 || signature !== last_sig) begin
                    n_bad++;
                    $display("FAIL idle_after n=%0d: busy=%b done=%b ui=%h sig=%h, required 0 0 00 %h",
                             n, busy, done, tile_ui_in, signature, last_sig);
                end
            end
            start = 1'b0;
            if (chain && k >= total + 1) start = 1'b1;
            if (mid && k < total && (k % 97) == 50) begin
                start = 1'b1;
                num_vectors = 8'($urandom_range(1, 255));
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        num_vectors = 8'd0;
        tile_loop = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || tile_ui_in !== 8'h00 || signature !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b ui=%h sig=%h, required 0 0 00 ffff",
                     busy, done, tile_ui_in, signature);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tile_ui_in !== 8'h00 || signature !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL idle_hold: busy=%b ui=%h sig=%h, required 0 00 ffff", busy, tile_ui_in, signature);
        end
    endtask

    task automatic test_single_loopback;
        do_run(1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (signature !== 16'hEFDE) begin
            n_bad++;
            $display("FAIL single_loop_sig: got %h required efde", signature);
        end
    endtask

    task automatic test_single_zero;
        do_run(1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (signature !== 16'hEFDF) begin
            n_bad++;
            $display("FAIL single_zero_sig: got %h required efdf", signature);
        end
    endtask

    task automatic test_five_loopback;
        do_run(5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full_256;
        do_run(0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_mid_run_reset;
        int seen_activity;
        tile_loop = 1'b1;
        num_vectors = 8'd5;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // cycle 8 is the middle of vector 3
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || tile_ui_in !== 8'h00 || signature !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL midrun_reset: busy=%b done=%b ui=%h sig=%h, required 0 0 00 ffff",
                     busy, done, tile_ui_in, signature);
        end
        rst_n = 1'b1;
        seen_activity = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_activity++;
        end
        n_cmp++;
        if (seen_activity != 0) begin
            n_bad++;
            $display("FAIL after_reset_quiet: active cycles=%0d required 0", seen_activity);
        end
        test_single_loopback();
    endtask

    task automatic test_back_to_back;
        int extra;
        do_run(1, 1'b1, 1'b0, 1'b1);
        do_run(2, 1'b1, 1'b0, 1'b0);
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL single_restart: extra busy cycles=%0d required 0", extra);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_sig = 16'hFFFF;
        rst_n = 1'b0;
        start = 1'b0;
        num_vectors = 8'd0;
        tile_loop = 1'b1;
        test_reset();
        test_single_loopback();
        test_single_zero();
        test_five_loopback();
        test_full_256();
        test_mid_run_reset();
        test_back_to_back();
        n_cmp++;
        if (exp_ui_q.size() != 0 || exp_sig_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: ui left=%0d sig left=%0d required 0 0",
                     exp_ui_q.size(), exp_sig_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
